// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory command bus between two requesters,
// running one command at a time and returning read data to whoever issued it.
module mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  // Requester handshake: rN_req is raised with its fields stable and held until
  // rN_gnt is seen; rN_gnt pulses for the single cycle the command is on the bus.
  state_t            state_q;
  logic              last_q;
  logic              win_q;
  logic [CW-1:0]     cnt_q;
  logic              r0_gnt_q, r1_gnt_q, r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wr_en_q, mem_rd_en_q;

  logic              grant_any;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_any = r0_req | r1_req;
    grant_id  = 1'b0;
    if (r1_req && (!r0_req || !last_q)) grant_id = 1'b1;
    sel_we    = grant_id ? r1_we    : r0_we;
    sel_addr  = grant_id ? r1_addr  : r0_addr;
    sel_wdata = grant_id ? r1_wdata : r0_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      cnt_q       <= '0;
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
    end else begin
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            state_q     <= ISSUE;
            r0_gnt_q    <= ~grant_id;
            r1_gnt_q    <= grant_id;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_wr_en_q <= sel_we;
            mem_rd_en_q <= ~sel_we;
            last_q      <= grant_id;
            win_q       <= grant_id;
          end
        end
        ISSUE: begin
          if (mem_wr_en_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CW'(RD_LAT - 1);
          end
        end
        WAIT: begin
          // Counter reaching zero marks the cycle mem_rdata is valid.
          if (cnt_q == '0) begin
            state_q <= IDLE;
            if (win_q) begin
              r1_rdata_q  <= mem_rdata;
              r1_rvalid_q <= 1'b1;
            end else begin
              r0_rdata_q  <= mem_rdata;
              r0_rvalid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_gnt    = r0_gnt_q;
  assign r1_gnt    = r1_gnt_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter sharing the single 4-entry × 8-bit memory (addr/wr_en/rd_en/wdata/rdata bus) between two requesters. It accepts one command at a time, serialises them onto the memory bus, captures read data after a fixed read latency and returns it to the issuing requester. It sits between the requester-side agents and the memory interface, and is the only driver of the memory command signals.

## Interface
- ADDR_W, 2, memory address width
- DATA_W, 8, memory data width
- RD_LAT, 1, cycles from the cycle `mem_rd_en` is high to the cycle `mem_rdata` is valid; must be ≥ 1
- clk  in  1  clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- rN_req  in  1  requester N (N = 0, 1) command pending; held with its fields until rN_gnt
- rN_we  in  1  1 = write, 0 = read
- rN_addr  in  ADDR_W  command address
- rN_wdata  in  DATA_W  write data
- rN_gnt  out  1  one-cycle pulse: command accepted and on the memory bus this cycle
- rN_rvalid  out  1  one-cycle pulse: rN_rdata valid
- rN_rdata  out  DATA_W  read data; holds last value otherwise
- mem_addr  out  ADDR_W  memory address
- mem_wr_en  out  1  memory write strobe
- mem_rd_en  out  1  memory read strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE: requests are sampled only here. If no request is pending, stay. If exactly one rN_req is high, that requester wins. If both are high, the winner is the requester not granted last, per the `last` pointer.
- IDLE → ISSUE on a win. At that edge, register rN_gnt=1 for the winner and load mem_addr/mem_wdata from its fields. Set mem_wr_en=rN_we and mem_rd_en=!rN_we. Update `last` to the winner. Latch the winner id.
- ISSUE: lasts one cycle. rN_gnt, mem_wr_en and mem_rd_en all clear at the next edge.
  - Write: ISSUE → IDLE.
  - Read: ISSUE → WAIT, with a wait counter loaded with RD_LAT−1 (width clog2(RD_LAT+1)).
- WAIT: decrement the counter each cycle. In the cycle the counter is 0, mem_rdata is valid. At that edge, capture it into rN_rdata of the latched winner, pulse its rN_rvalid, and go to IDLE.
- rN_rdata of the non-issuing requester is never modified.
- mem_addr and mem_wdata hold their last values when no strobe is asserted.
- A requester drops or changes req only after sampling gnt. Dropping req before gnt is a protocol violation, and the arbiter behaviour is then undefined.
- Never more than one command in flight. mem_wr_en and mem_rd_en are never both 1. rN_gnt is never asserted for both N in the same cycle.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, last=1 (so r0 wins the first tie), wait counter=0. All outputs 0: gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wr_en, mem_rd_en.
- Reset mid-operation: any in-flight read is discarded and no rvalid is produced. Operation resumes from IDLE on the first edge after release.
- Write latency: req seen high in IDLE at cycle T gives gnt, mem_wr_en and the command in cycle T+1. The arbiter is back in IDLE at T+2, so there is one write per 2 cycles.
- Read latency: gnt and mem_rd_en in cycle T+1. mem_rdata is valid in cycle T+1+RD_LAT. rN_rvalid and rN_rdata appear in cycle T+2+RD_LAT, with the arbiter in IDLE that same cycle.
- rvalid for one read can coincide with a new req sampled in IDLE. That new request produces a gnt the following cycle.
- A requester holding req continuously after gnt is treated as a new request and re-arbitrated in the next IDLE.

## Test plan
- Reset then single write: r0_req=1, we=1, addr=2, wdata=0xA5 → r0_gnt and mem_wr_en high 1 cycle later with mem_addr=2, mem_wdata=0xA5. r1_gnt stays 0.
- Read-back, RD_LAT=1: r1 reads addr=2 after the above write → mem_rd_en 1 cycle after req is sampled. r1_rvalid=1 with r1_rdata=0xA5 exactly 3 cycles after req is sampled. r0_rdata is unchanged.
- Tie after reset: both req, writes to addr 0 (0x11) and addr 1 (0x22) → r0 granted first, r1 granted 2 cycles later. The memory then holds 0x11 and 0x22.
- Sustained contention: both req held high for 8 write grants → grants alternate r0, r1, r0, … with a gnt every 2 cycles.
- Latency parameter: RD_LAT=3, r0 reads → r0_rvalid 5 cycles after req is sampled, no earlier or later. No gnt is issued during WAIT even with r1_req high.
- Reset mid-read: reset=0 asserted during WAIT → all outputs 0 immediately. After release no rvalid appears, and a new tie is granted to r0.
